l1_dcache: RTL and testbench
============================

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and the L2 cache.
- Serves single-word CPU reads and writes, and exchanges whole blocks with the L2 over the L2's L1-side interface.
- This block is the L1 master of that interface: it drives address, read/write strobes and victim data; the L2 returns ready, hit and fill data.
- All addresses are word addresses. Offset selects a word within a block.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, word-address width
- CACHE_SIZE, 256, capacity in words; NUM_LINES = CACHE_SIZE/BLOCK_SIZE
- BLOCK_SIZE, 16, words per block; must match the L2 setting

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  ADDR_WIDTH  word address of the request
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_read  in  1  load request, held until cpu_ready
- cpu_write  in  1  store request, held until cpu_ready
- cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  qualifies cpu_ready: 1 = L1 hit, 0 = completed via refill
- l2_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0)
- l2_data_out  out  BLOCK_SIZE*DATA_WIDTH  victim block for write-back
- l2_read  out  1  block fetch request
- l2_write  out  1  block write-back request
- l2_block_data  in  BLOCK_SIZE*DATA_WIDTH  fill data
- l2_block_valid  in  1  fill data valid
- l2_ready  in  1  L2 completed the current request
- l2_hit  in  1  informational only; not used for control

Behaviour:
- Address split:
  - offset = addr[OW-1:0], OW = clog2(BLOCK_SIZE)
  - index = next IW bits, IW = clog2(NUM_LINES)
  - tag = remainder
- Per-line storage: tag, block data, valid, dirty.
- Reset (async, any state):
  - state=IDLE; all valid and dirty bits = 0.
  - All outputs 0: cpu_ready, cpu_hit, cpu_rdata, l2_read, l2_write, l2_addr, l2_data_out.
  - An in-flight L2 transaction is abandoned; the strobes drop in the reset cycle.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND.
- IDLE:
  - If cpu_read or cpu_write is set and cpu_ready was 0 last cycle, latch addr, wdata and op; go to COMPARE.
  - If both strobes are set, write wins.
  - Requests are ignored in the cycle cpu_ready is high.
- COMPARE:
  - Hit (valid && tag match): a load returns the offset word; a store merges wdata and sets dirty.
  - On hit, the next cycle has cpu_ready=1, cpu_hit=1; return to IDLE.
  - Hit latency: request seen at edge N, cpu_ready high in cycle N+2.
  - Miss with victim valid && dirty: go to WRITE_BACK.
  - Miss otherwise: go to ALLOCATE.
- WRITE_BACK:
  - Drive l2_write=1, l2_addr={victim tag, index, 0}, l2_data_out=victim block.
  - Hold all of these stable until l2_ready=1, then go to ALLOCATE.
- ALLOCATE:
  - Drive l2_read=1, l2_addr={tag, index, 0}.
  - On l2_ready && l2_block_valid, install the block: tag, valid=1, dirty=0.
  - If the op is a store, merge wdata at offset and set dirty=1.
  - Go to RESPOND.
  - l2_ready without l2_block_valid is ignored; stay in ALLOCATE.
- RESPOND: cpu_ready=1, cpu_hit=0, cpu_rdata = installed word (load) or 0 (store); go to IDLE.
- Outputs are registered. l2_read and l2_write are never high together, and each is asserted only in its own state.
- No wait limit: the block waits indefinitely for L2.
- Data for non-load completions: cpu_rdata=0.

Test Plan:
- Reset; read 0x14; L2 returns a block with word k = 0xA000_0000+k, 3 cycles after l2_read -> l2_read with l2_addr=0x10, no l2_write; cpu_rdata=0xA000_0004, cpu_hit=0. Re-read 0x14 -> cpu_ready 2 cycles after request, cpu_hit=1, no L2 strobes.
- Write 0x15 data 0xDEAD_BEEF -> hit, 2-cycle completion. Read 0x15 -> 0xDEAD_BEEF.
- Read 0x115 (index 1, new tag) -> l2_write at 0x10 with word5=0xDEAD_BEEF and word4=0xA000_0004, held until l2_ready. Then l2_read at 0x110. cpu_hit=0.
- Write miss 0x223 data 0x1234_5678 to an empty line -> l2_read 0x220 only, no write-back. Subsequent read of 0x223 hits and returns 0x1234_5678.
- In ALLOCATE, L2 pulses l2_ready with l2_block_valid=0 -> no install, l2_read stays high. A later ready+valid completes normally.
- Assert rst mid-ALLOCATE -> l2_read=0 in the same cycle. After release, read 0x14 misses (l2_read to 0x10).

Source files
------------

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Serves single-word CPU loads/stores and moves whole blocks to and from the L2.
module l1_dcache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CACHE_SIZE = 256,
    parameter int unsigned BLOCK_SIZE = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic                             cpu_ready,
    output logic                             cpu_hit,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data,
    input  logic                             l2_block_valid,
    input  logic                             l2_ready,
    input  logic                             l2_hit
);
    localparam int unsigned NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
    localparam int unsigned OW        = $clog2(BLOCK_SIZE);
    localparam int unsigned IW        = $clog2(NUM_LINES);
    localparam int unsigned TW        = ADDR_WIDTH - OW - IW;
    localparam int unsigned BW        = BLOCK_SIZE * DATA_WIDTH;
    localparam int unsigned SW        = $clog2(BW);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        RESPOND
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_op_wr;
    logic [NUM_LINES-1:0]    r_valid;
    logic [NUM_LINES-1:0]    r_dirty;
    logic [TW-1:0]           r_tag  [NUM_LINES];
    logic [BW-1:0]           r_data [NUM_LINES];

    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic                    r_cpu_ready;
    logic                    r_cpu_hit;
    logic [ADDR_WIDTH-1:0]   r_l2_addr;
    logic [BW-1:0]           r_l2_data_out;
    logic                    r_l2_read;
    logic                    r_l2_write;

    logic [OW-1:0]           w_off;
    logic [IW-1:0]           w_idx;
    logic [TW-1:0]           w_tag;
    logic [TW-1:0]           w_line_tag;
    logic [BW-1:0]           w_line;
    logic [SW-1:0]           w_bit_off;
    logic                    w_hit;
    logic                    w_fill;
    logic                    w_store_hit;
    logic [BW-1:0]           w_fill_block;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   w_fill_word;
    logic                    w_unused;

    assign w_off       = r_addr[OW-1:0];
    assign w_idx       = r_addr[OW +: IW];
    assign w_tag       = r_addr[ADDR_WIDTH-1 -: TW];
    assign w_line_tag  = r_tag[w_idx];
    assign w_line      = r_data[w_idx];
    assign w_bit_off   = SW'(w_off) * SW'(DATA_WIDTH);
    assign w_hit       = r_valid[w_idx] && (w_line_tag == w_tag);
    assign w_fill      = (r_state == ALLOCATE) && l2_ready && l2_block_valid;
    assign w_store_hit = (r_state == COMPARE) && w_hit && r_op_wr;
    assign w_word      = w_line[w_bit_off +: DATA_WIDTH];
    assign w_fill_word = w_fill_block[w_bit_off +: DATA_WIDTH];
    assign w_unused    = l2_hit;

    // Incoming fill block with a pending store already merged in
    always_comb begin
        w_fill_block = l2_block_data;
        if (r_op_wr) begin
            w_fill_block[w_bit_off +: DATA_WIDTH] = r_wdata;
        end
    end

    // Tag/data arrays carry no reset; validity is tracked by r_valid
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx] <= w_fill_block;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_idx][w_bit_off +: DATA_WIDTH] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_op_wr       <= 1'b0;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_cpu_rdata   <= '0;
            r_cpu_ready   <= 1'b0;
            r_cpu_hit     <= 1'b0;
            r_l2_addr     <= '0;
            r_l2_data_out <= '0;
            r_l2_read     <= 1'b0;
            r_l2_write    <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_cpu_rdata <= '0;
            case (r_state)
                IDLE: begin
                    // The cycle after a completion still shows the old request; skip it
                    if ((cpu_read || cpu_write) && !r_cpu_ready) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_op_wr <= cpu_write;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_hit   <= 1'b1;
                        if (r_op_wr) begin
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_word;
                        end
                        r_state <= IDLE;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_l2_write    <= 1'b1;
                        r_l2_addr     <= {w_line_tag, w_idx, OW'(0)};
                        r_l2_data_out <= w_line;
                        r_state       <= WRITE_BACK;
                    end else begin
                        r_l2_read <= 1'b1;
                        r_l2_addr <= {w_tag, w_idx, OW'(0)};
                        r_state   <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (l2_ready) begin
                        r_l2_write    <= 1'b0;
                        r_l2_data_out <= '0;
                        r_l2_read     <= 1'b1;
                        r_l2_addr     <= {w_tag, w_idx, OW'(0)};
                        r_state       <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (w_fill) begin
                        r_l2_read      <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= r_op_wr;
                        r_cpu_ready    <= 1'b1;
                        r_cpu_rdata    <= r_op_wr ? '0 : w_fill_word;
                        r_state        <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_ready   = r_cpu_ready;
    assign cpu_hit     = r_cpu_hit;
    assign l2_addr     = r_l2_addr;
    assign l2_data_out = r_l2_data_out;
    assign l2_read     = r_l2_read;
    assign l2_write    = r_l2_write;
endmodule

// File: tb/tb_l1_dcache.sv
// Directed self-checking bench for l1_dcache with a hand-driven L2 responder.
module tb_l1_dcache;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BS = 16;
    localparam int unsigned BW = BS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;
    logic          cpu_hit;
    logic [AW-1:0] l2_addr;
    logic [BW-1:0] l2_data_out;
    logic          l2_read;
    logic          l2_write;
    logic [BW-1:0] l2_block_data;
    logic          l2_block_valid;
    logic          l2_ready;
    logic          l2_hit;

    int n_cmp = 0;
    int n_err = 0;

    l1_dcache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(256), .BLOCK_SIZE(BS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .l2_addr(l2_addr), .l2_data_out(l2_data_out),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_block_data(l2_block_data), .l2_block_valid(l2_block_valid),
        .l2_ready(l2_ready), .l2_hit(l2_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // The two L2 strobes must never be high together
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            assert (!(l2_read && l2_write)) else begin
                n_err++;
                $error("FAIL strobe_excl: observed=1 expected=0");
            end
        end
    end

    function automatic logic [BW-1:0] make_block(input logic [31:0] base);
        logic [BW-1:0] b;
        for (int k = 0; k < int'(BS); k++) begin
            b[k*32 +: 32] = base + 32'(k);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic [31:0] addr, input logic [31:0] data, input bit wr);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = wr;
        cpu_read  = !wr;
    endtask

    task automatic cpu_done();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        step();
    endtask

    task automatic wait_ready(output int cyc, output bit saw_l2);
        cyc    = 0;
        saw_l2 = 1'b0;
        while (!cpu_ready && cyc < 30) begin
            step();
            cyc++;
            if (l2_read || l2_write) saw_l2 = 1'b1;
        end
        chk("ready_seen", 32'(cpu_ready), 1);
    endtask

    task automatic wait_l2_read(output bit saw_wr);
        int cnt;
        cnt    = 0;
        saw_wr = l2_write;
        while (!l2_read && cnt < 30) begin
            step();
            cnt++;
            if (l2_write) saw_wr = 1'b1;
        end
        chk("l2_read_seen", 32'(l2_read), 1);
    endtask

    // Waits for a fetch, checks its address, answers after `delay` cycles
    task automatic serve_fill(input string tag, input logic [31:0] exp_addr,
                              input logic [BW-1:0] blk, input int delay);
        bit saw_wr;
        wait_l2_read(saw_wr);
        chk({tag, "_addr"}, l2_addr, exp_addr);
        chk({tag, "_no_wb"}, 32'(saw_wr), 0);
        repeat (delay - 1) step();
        l2_block_data  = blk;
        l2_ready       = 1'b1;
        l2_block_valid = 1'b1;
        step();
        l2_ready       = 1'b0;
        l2_block_valid = 1'b0;
        chk({tag, "_rd_drop"}, 32'(l2_read), 0);
    endtask

    int cyc;
    bit saw;

    initial begin
        rst            = 1'b1;
        cpu_addr       = '0;
        cpu_wdata      = '0;
        cpu_read       = 1'b0;
        cpu_write      = 1'b0;
        l2_block_data  = '0;
        l2_block_valid = 1'b0;
        l2_ready       = 1'b0;
        l2_hit         = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(cpu_ready), 0);
        chk("rst_hit", 32'(cpu_hit), 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_l2_read", 32'(l2_read), 0);
        chk("rst_l2_write", 32'(l2_write), 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_l2_data", 32'(l2_data_out != '0), 0);
        rst = 1'b0;
        step();

        // Cold read miss
        cpu_req(32'h14, 0, 1'b0);
        serve_fill("miss14", 32'h10, make_block(32'hA000_0000), 3);
        chk("miss14_ready", 32'(cpu_ready), 1);
        chk("miss14_hit", 32'(cpu_hit), 0);
        chk("miss14_rdata", cpu_rdata, 32'hA000_0004);
        cpu_done();
        chk("post_resp_ready", 32'(cpu_ready), 0);

        // Read hit latency
        cpu_req(32'h14, 0, 1'b0);
        wait_ready(cyc, saw);
        chk("hit14_lat", 32'(cyc), 2);
        chk("hit14_hit", 32'(cpu_hit), 1);
        chk("hit14_rdata", cpu_rdata, 32'hA000_0004);
        chk("hit14_no_l2", 32'(saw), 0);
        cpu_done();

        // Store hit then load it back
        cpu_req(32'h15, 32'hDEAD_BEEF, 1'b1);
        wait_ready(cyc, saw);
        chk("wr15_lat", 32'(cyc), 2);
        chk("wr15_hit", 32'(cpu_hit), 1);
        chk("wr15_rdata", cpu_rdata, 0);
        chk("wr15_no_l2", 32'(saw), 0);
        cpu_done();
        cpu_req(32'h15, 0, 1'b0);
        wait_ready(cyc, saw);
        chk("rd15_hit", 32'(cpu_hit), 1);
        chk("rd15_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_done();

        // Conflict miss evicting the dirty line
        cpu_req(32'h115, 0, 1'b0);
        cyc = 0;
        while (!l2_write && cyc < 30) begin
            step();
            cyc++;
        end
        chk("wb_seen", 32'(l2_write), 1);
        chk("wb_addr", l2_addr, 32'h10);
        chk("wb_word5", l2_data_out[5*32 +: 32], 32'hDEAD_BEEF);
        chk("wb_word4", l2_data_out[4*32 +: 32], 32'hA000_0004);
        chk("wb_no_read", 32'(l2_read), 0);
        repeat (3) begin
            step();
            chk("wb_hold_write", 32'(l2_write), 1);
            chk("wb_hold_addr", l2_addr, 32'h10);
            chk("wb_hold_word5", l2_data_out[5*32 +: 32], 32'hDEAD_BEEF);
        end
        l2_ready = 1'b1;
        step();
        l2_ready = 1'b0;
        chk("wb_done_write", 32'(l2_write), 0);
        serve_fill("miss115", 32'h110, make_block(32'hB000_0000), 3);
        chk("miss115_ready", 32'(cpu_ready), 1);
        chk("miss115_hit", 32'(cpu_hit), 0);
        chk("miss115_rdata", cpu_rdata, 32'hB000_0005);
        cpu_done();

        // Write miss to an empty line, then read back
        cpu_req(32'h223, 32'h1234_5678, 1'b1);
        serve_fill("wmiss223", 32'h220, make_block(32'hC000_0000), 3);
        chk("wmiss223_ready", 32'(cpu_ready), 1);
        chk("wmiss223_hit", 32'(cpu_hit), 0);
        chk("wmiss223_rdata", cpu_rdata, 0);
        cpu_done();
        cpu_req(32'h223, 0, 1'b0);
        wait_ready(cyc, saw);
        chk("rd223_lat", 32'(cyc), 2);
        chk("rd223_hit", 32'(cpu_hit), 1);
        chk("rd223_rdata", cpu_rdata, 32'h1234_5678);
        cpu_done();

        // l2_ready without block_valid must be ignored
        cpu_req(32'h335, 0, 1'b0);
        wait_l2_read(saw);
        chk("spur_addr", l2_addr, 32'h330);
        l2_block_data  = make_block(32'hEEEE_0000);
        l2_ready       = 1'b1;
        l2_block_valid = 1'b0;
        step();
        l2_ready = 1'b0;
        chk("spur_read_held", 32'(l2_read), 1);
        chk("spur_no_ready", 32'(cpu_ready), 0);
        step();
        chk("spur_read_held2", 32'(l2_read), 1);
        serve_fill("miss335", 32'h330, make_block(32'hD000_0000), 2);
        chk("miss335_ready", 32'(cpu_ready), 1);
        chk("miss335_rdata", cpu_rdata, 32'hD000_0005);
        cpu_done();
        cpu_req(32'h335, 0, 1'b0);
        wait_ready(cyc, saw);
        chk("rd335_hit", 32'(cpu_hit), 1);
        chk("rd335_rdata", cpu_rdata, 32'hD000_0005);
        cpu_done();

        // Asynchronous reset while fetching
        cpu_req(32'h4A0, 0, 1'b0);
        wait_l2_read(saw);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_l2_read", 32'(l2_read), 0);
        chk("arst_ready", 32'(cpu_ready), 0);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Lines are invalid after reset; a formerly dirty line is not written back
        cpu_req(32'h14, 0, 1'b0);
        serve_fill("rmiss14", 32'h10, make_block(32'hA000_0000), 2);
        chk("rmiss14_hit", 32'(cpu_hit), 0);
        chk("rmiss14_rdata", cpu_rdata, 32'hA000_0004);
        cpu_done();
        cpu_req(32'h223, 0, 1'b0);
        serve_fill("rmiss223", 32'h220, make_block(32'hC000_0000), 1);
        chk("rmiss223_hit", 32'(cpu_hit), 0);
        chk("rmiss223_rdata", cpu_rdata, 32'hC000_0003);
        cpu_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
